opram_sp: RTL and testbench



---
 rtl/opram_pkg.sv | 14 +
 rtl/opram_clr_seq.sv | 57 +++++
 rtl/opram_sp.sv | 91 +++++++++
 tb/tb_opram_sp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opram_pkg.sv
// Shared constants for the opram_sp operand RAM: write-mode codes and the
// clear-sequencer state encoding.
package opram_pkg;

  localparam logic [1:0] WM_NORMAL      = 2'd0;
  localparam logic [1:0] WM_WRITE_THRU  = 2'd1;
  localparam logic [1:0] WM_READ_BEFORE = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/opram_clr_seq.sv
// Clear sequencer for opram_sp: sweeps every address once, writing zero,
// after reset (when CLR_ON_RESET is set) or on a clr request.
module opram_clr_seq
  import opram_pkg::*;
#(
  parameter int AW           = 3,
  parameter int CLR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] clr_ad,
  output logic          clr_we
);

  clr_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ad <= '0;
      if (CLR_ON_RESET != 0) begin
        state <= ST_CLEAR;
        busy  <= 1'b1;
      end else begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state  <= ST_CLEAR;
            busy   <= 1'b1;
            clr_ad <= '0;
          end
        end
        ST_CLEAR: begin
          // clr is ignored here: a running sweep never restarts
          clr_ad <= clr_ad + 1'b1;
          if (clr_ad == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A reset edge abandons the sweep without writing the current word
  assign clr_we = (state == ST_CLEAR) && !reset;

endmodule

// File: rtl/opram_sp.sv
// Parametrised single-port synchronous RAM with write-mode selection and a
// hardware clear sweep. Optional output register: define OPRAM_PIPE_EN.
module opram_sp
  import opram_pkg::*;
#(
  parameter int DW           = 8,
  parameter int AW           = 3,
  parameter int WRITE_MODE   = 0,
  parameter int CLR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          oce,
  input  logic          wre,
  input  logic [AW-1:0] ad,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          busy,
  output logic [DW-1:0] dout
);

  // Out-of-range modes fall back to normal (hold)
  localparam logic [1:0] WM_SEL = (WRITE_MODE == 1) ? WM_WRITE_THRU  :
                                  (WRITE_MODE == 2) ? WM_READ_BEFORE :
                                                      WM_NORMAL;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] stage_p1;
  logic [AW-1:0] clr_ad;
  logic          clr_we;
  logic          user_acc;
  logic          user_wr;

  opram_clr_seq #(
    .AW           (AW),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clr_seq (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .busy   (busy),
    .clr_ad (clr_ad),
    .clr_we (clr_we)
  );

  assign user_acc = ce && !busy && !reset;
  assign user_wr  = user_acc && wre;

  // Array write port: the sweep owns it whenever it is running
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ad] <= '0;
    end else if (user_wr) begin
      mem[ad] <= din;
    end
  end

  // ---- stage p1: read / write-mode capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_p1 <= '0;
    end else if (user_acc) begin
      if (!wre || (WM_SEL == WM_READ_BEFORE)) begin
        stage_p1 <= mem[ad];
      end else if (WM_SEL == WM_WRITE_THRU) begin
        stage_p1 <= din;
      end
    end
  end

`ifdef OPRAM_PIPE_EN
  // ---- stage p2: optional output register ----
  logic [DW-1:0] dout_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_p2 <= '0;
    end else if (oce && !busy) begin
      dout_p2 <= stage_p1;
    end
  end

  assign dout = dout_p2;
`else
  logic unused_oce;
  assign unused_oce = oce;
  assign dout       = stage_p1;
`endif

endmodule

// File: tb/tb_opram_sp.sv
// Self-checking bench for opram_sp: write modes, clear sweeps, reset during
// a sweep, a wide/deep instance, and a randomized run against a model.
module tb_opram_sp;

`ifdef OPRAM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, ce, oce, wre, clr;
  logic [2:0]  ad;
  logic [7:0]  din;
  logic        ce4, wre4;
  logic [5:0]  ad4;
  logic [15:0] din4;
  logic        clr4;

  logic [7:0]  dout0, dout1, dout2, dout3;
  logic [15:0] dout4;
  logic        busy0, busy1, busy2, busy3, busy4;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model for the three 8x8 instances sharing one stimulus bus
  logic [7:0] mm [8];
  logic [7:0] exp_d [3];

  always #5 clk = ~clk;

  opram_sp #(.DW(8), .AW(3), .WRITE_MODE(0), .CLR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .clr(clr), .busy(busy0), .dout(dout0));
  opram_sp #(.DW(8), .AW(3), .WRITE_MODE(1), .CLR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .clr(clr), .busy(busy1), .dout(dout1));
  opram_sp #(.DW(8), .AW(3), .WRITE_MODE(2), .CLR_ON_RESET(1)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .clr(clr), .busy(busy2), .dout(dout2));
  opram_sp #(.DW(8), .AW(3), .WRITE_MODE(0), .CLR_ON_RESET(0)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .clr(clr), .busy(busy3), .dout(dout3));
  opram_sp #(.DW(16), .AW(6), .WRITE_MODE(0), .CLR_ON_RESET(1)) u4 (
    .clk(clk), .reset(reset), .ce(ce4), .oce(oce), .wre(wre4), .ad(ad4),
    .din(din4), .clr(clr4), .busy(busy4), .dout(dout4));

  typedef struct {
    logic [2:0] ad;
    logic [7:0] wd;
    logic [7:0] rd_exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " wm0"}, {24'd0, dout0}, {24'd0, exp_d[0]});
    chk({nm, " wm1"}, {24'd0, dout1}, {24'd0, exp_d[1]});
    chk({nm, " wm2"}, {24'd0, dout2}, {24'd0, exp_d[2]});
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] old;
    ce = 1'b1; wre = 1'b1; ad = a; din = d;
    tick();
    ce = 1'b0; wre = 1'b0;
    repeat (LAT - 1) tick();
    old      = mm[a];
    mm[a]    = d;
    exp_d[1] = d;
    exp_d[2] = old;
  endtask

  task automatic rd(input logic [2:0] a);
    ce = 1'b1; wre = 1'b0; ad = a;
    tick();
    ce = 1'b0;
    repeat (LAT - 1) tick();
    for (int k = 0; k < 3; k++) exp_d[k] = mm[a];
  endtask

  task automatic wait_idle(input string nm);
    int cnt = 0;
    while (busy0 && cnt < 200) begin
      tick();
      cnt++;
    end
    if (busy0) chk({nm, " busy timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    int   cnt0, cnt4, cnt;
    logic [7:0] hold;

    vecs[0] = '{3'd3, 8'hA5, 8'hA5};
    vecs[1] = '{3'd0, 8'h3C, 8'h3C};
    vecs[2] = '{3'd7, 8'h81, 8'h81};
    vecs[3] = '{3'd1, 8'hFF, 8'hFF};

    reset = 1'b1; ce = 1'b0; oce = 1'b1; wre = 1'b0; clr = 1'b0;
    ad = '0; din = '0;
    ce4 = 1'b0; wre4 = 1'b0; ad4 = '0; din4 = '0; clr4 = 1'b0;
    for (int i = 0; i < 3; i++) exp_d[i] = 8'h00;
    tick(); tick();

    // Reset state
    chk("reset dout0", {24'd0, dout0}, 32'h0);
    chk("reset dout3", {24'd0, dout3}, 32'h0);
    chk("reset dout4", {16'd0, dout4}, 32'h0);
    chk("reset busy0", {31'd0, busy0}, 32'd1);
    chk("reset busy3", {31'd0, busy3}, 32'd0);

    // Post-reset sweep lengths: 8 cycles for AW=3, 64 for AW=6
    reset = 1'b0;
    cnt = 0; cnt0 = -1; cnt4 = -1;
    while ((cnt0 < 0 || cnt4 < 0) && cnt < 200) begin
      tick();
      cnt++;
      if (cnt0 < 0 && !busy0) cnt0 = cnt;
      if (cnt4 < 0 && !busy4) cnt4 = cnt;
    end
    chk("sweep len aw3", cnt0, 32'd8);
    chk("sweep len aw6", cnt4, 32'd64);
    for (int i = 0; i < 8; i++) mm[i] = 8'h00;

    for (int a = 0; a < 8; a++) begin
      rd(a[2:0]);
      chk_model($sformatf("cleared rd%0d", a));
    end

    // Wide/deep instance: top address and wrap
    ce4 = 1'b1; wre4 = 1'b1; ad4 = 6'd63; din4 = 16'hBEEF; tick();
    ad4 = 6'd0; din4 = 16'h1234; tick();
    wre4 = 1'b0; ad4 = 6'd63; tick();
    ce4 = 1'b0; repeat (LAT - 1) tick();
    chk("aw6 rd63", {16'd0, dout4}, 32'hBEEF);
    ce4 = 1'b1; ad4 = 6'd62; tick();
    ce4 = 1'b0; repeat (LAT - 1) tick();
    chk("aw6 rd62", {16'd0, dout4}, 32'h0000);
    ce4 = 1'b1; ad4 = 6'd63 + 6'd1; tick();
    ce4 = 1'b0; repeat (LAT - 1) tick();
    chk("aw6 rd wrap0", {16'd0, dout4}, 32'h1234);

    // Table-driven write then read-back
    foreach (vecs[i]) wr(vecs[i].ad, vecs[i].wd);
    foreach (vecs[i]) begin
      rd(vecs[i].ad);
      chk($sformatf("table rd%0d", vecs[i].ad), {24'd0, dout0}, {24'd0, vecs[i].rd_exp});
    end

    // Write-mode behaviour on a write over an existing word
    wr(3'd5, 8'h11);
    rd(3'd2);
    wr(3'd5, 8'h22);
    chk_model("wmode write");
    chk("wm2 old word", {24'd0, dout2}, 32'h11);
    chk("wm1 new word", {24'd0, dout1}, 32'h22);
    rd(3'd5);
    chk_model("wmode readback");

    // Back-to-back write then read of the same address
    ce = 1'b1; wre = 1'b1; ad = 3'd6; din = 8'h5C; tick();
    wre = 1'b0; tick();
    ce = 1'b0; repeat (LAT - 1) tick();
    mm[6] = 8'h5C;
    for (int k = 0; k < 3; k++) exp_d[k] = 8'h5C;
    chk_model("b2b wr-rd");

`ifdef OPRAM_PIPE_EN
    // oce low: output register holds while the stage register advances
    hold = exp_d[0];
    oce = 1'b0;
    ce = 1'b1; wre = 1'b0; ad = 3'd3; tick();
    ce = 1'b0; tick();
    chk("oce0 hold", {24'd0, dout0}, {24'd0, hold});
    oce = 1'b1; tick();
    chk("oce1 load", {24'd0, dout0}, {24'd0, mm[3]});
    for (int k = 0; k < 3; k++) exp_d[k] = mm[3];
`else
    hold = 8'h00;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(1, 0) == 1) wr(3'($urandom_range(7, 0)), 8'($urandom));
      else                           rd(3'($urandom_range(7, 0)));
      if (n % 10 == 0) chk_model($sformatf("rand%0d", n));
    end

    // clr sweep over a full array, with a write and a second clr mid-sweep
    for (int a = 0; a < 8; a++) wr(a[2:0], 8'hFF);
    clr = 1'b1; tick(); clr = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 50) begin
      ce  = (cnt == 3);
      wre = (cnt == 3);
      ad  = 3'd0;
      din = 8'h5A;
      clr = (cnt == 5);
      tick();
      cnt++;
    end
    ce = 1'b0; wre = 1'b0; clr = 1'b0;
    chk("clr sweep len", cnt, 32'd8);
    chk_model("dout held in sweep");
    for (int i = 0; i < 8; i++) mm[i] = 8'h00;
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0]);
      chk_model($sformatf("post-clr rd%0d", a));
    end

    // Reset on the 4th sweep cycle of the no-reset-sweep instance
    for (int a = 0; a < 8; a++) wr(a[2:0], 8'hFF);
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort busy3", {31'd0, busy3}, 32'd0);
    chk("abort dout3", {24'd0, dout3}, 32'd0);
    wait_idle("reclear");
    for (int i = 0; i < 8; i++) mm[i] = 8'h00;
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0]);
      chk($sformatf("partial rd%0d", a), {24'd0, dout3}, (a < 3) ? 32'h00 : 32'hFF);
      chk_model($sformatf("reswept rd%0d", a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
